// File: rtl/shift_add_mult_ctrl_if.sv
// Start/done handshake and multiplier-shift-register strobes for the shift-add multiplier.
// start is a level request, looked at only while idle; done is a one-cycle pulse, and product holds until the next accepted start.
interface shift_add_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic                 lsb;
  logic                 load;
  logic                 shift;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, lsb,
    input  load, shift, busy, done, product
  );

  modport slave (
    input  start, multiplicand, lsb,
    output load, shift, busy, done, product
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer and accumulator for an iterative shift-add multiplier: it loads the external
// multiplier register, then does WIDTH shift/accumulate steps and pulses done.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_add_mult_ctrl_if.slave bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d   = {{WIDTH{1'b0}}, bus.multiplicand};
          product_d = '0;
          cnt_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // The multiplicand is pre-shifted each step, so the running sum is a plain add.
        if (bus.lsb) product_d = product_q + mcand_q;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.load    = (state_q == LOAD);
  assign bus.shift   = (state_q == RUN);
  assign bus.busy    = (state_q == LOAD) || (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: it models the external multiplier shift register and
// checks strobe timing, products, ignored starts, aborts and back-to-back operation.
module tb_shift_add_mult_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] state_o;
  logic [W-1:0] mult_op = '0;
  logic [W-1:0] mreg;
  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_mult_ctrl_if #(.WIDTH(W)) bus_if ();

  shift_add_mult_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural model of the multiplier shift register that sits beside the controller.
  always @(posedge clk or posedge reset) begin
    if (reset) mreg <= '0;
    else if (bus_if.load) mreg <= mult_op;
    else if (bus_if.shift) mreg <= mreg >> 1;
  end
  assign bus_if.lsb = mreg[0];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = a;
    mult_op             = b;
    exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0;
    bus_if.multiplicand = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== 2'd0 || bus_if.product !== '0) begin
      failures++;
      $display("FAIL reset_state: state=%0d product=%h required state=0 product=0", state_o, bus_if.product);
    end
    checks++;
    if ({bus_if.load, bus_if.shift, bus_if.busy, bus_if.done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: l/s/b/d=%b required 0000", {bus_if.load, bus_if.shift, bus_if.busy, bus_if.done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_products();
    logic [W-1:0] av[5];
    logic [W-1:0] bv[5];
    logic [3:0] exp_f;
    logic [1:0] exp_s;
    logic [2*W-1:0] e;
    av[0] = 32'd5;        bv[0] = 32'd3;
    av[1] = 32'hFFFFFFFF; bv[1] = 32'hFFFFFFFF;
    av[2] = 32'h12345678; bv[2] = 32'd0;
    av[3] = $urandom;     bv[3] = $urandom;
    av[4] = $urandom_range(0, 65535); bv[4] = $urandom;
    for (int k = 0; k < 5; k++) begin
      issue(av[k], bv[k]);
      @(posedge clk);
      for (int c = 1; c <= 35; c++) begin
        @(negedge clk);
        if (c == 1) bus_if.start = 1'b0;
        exp_f = {c == 1, c >= 2 && c <= 33, c <= 33, c == 34};
        exp_s = (c == 1) ? 2'd1 : (c <= 33) ? 2'd2 : (c == 34) ? 2'd3 : 2'd0;
        checks++;
        if ({bus_if.load, bus_if.shift, bus_if.busy, bus_if.done} !== exp_f || state_o !== exp_s) begin
          failures++;
          $display("FAIL timing op%0d cycle %0d: l/s/b/d=%b state=%0d required %b state=%0d",
                   k, c, {bus_if.load, bus_if.shift, bus_if.busy, bus_if.done}, state_o, exp_f, exp_s);
        end
        if (bus_if.done) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL product op%0d: done with nothing expected, product=%h", k, bus_if.product);
          end else begin
            e = exp_q.pop_front();
            if (bus_if.product !== e) begin
              failures++;
              $display("FAIL product op%0d: got %h required %h", k, bus_if.product, e);
            end
          end
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    logic [2*W-1:0] e;
    issue(32'd7, 32'd9);
    @(posedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      bus_if.start = (c == 5 || c == 20);
      if (bus_if.done) begin
        dones++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (c != 34 || bus_if.product !== e) begin
          failures++;
          $display("FAIL ignored_start: done at cycle %0d product=%h required cycle 34 product=%h", c, bus_if.product, e);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignored_start_count: dones=%0d required 1", dones);
    end
    exp_q.delete();
  endtask

  task automatic test_abort();
    int dones = 0;
    logic [2*W-1:0] e;
    issue(32'd11, 32'hFFFF);
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== 2'd0 || bus_if.product !== '0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: state=%0d product=%h busy=%b required 0/0/0", state_o, bus_if.product, bus_if.busy);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: dones=%0d required 0", dones);
    end
    issue(32'd2, 32'd6);
    @(posedge clk);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.start = 1'b0;
    end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    if (bus_if.done !== 1'b1 || bus_if.product !== e) begin
      failures++;
      $display("FAIL after_abort: done=%b product=%h required 1 %h", bus_if.done, bus_if.product, e);
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] e;
    issue(32'd4, 32'd4);
    @(posedge clk);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      checks++;
      if (bus_if.done !== (c == 34 || c == 69)) begin
        failures++;
        $display("FAIL b2b_done cycle %0d: done=%b required %b", c, bus_if.done, (c == 34 || c == 69));
      end
      if (bus_if.done) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (bus_if.product !== e) begin
          failures++;
          $display("FAIL b2b_product cycle %0d: got %h required %h", c, bus_if.product, e);
        end
      end
      if (c == 35) begin
        checks++;
        if (bus_if.product !== 64'd16 || state_o !== 2'd0) begin
          failures++;
          $display("FAIL b2b_hold: product=%h state=%0d required 16 state=0", bus_if.product, state_o);
        end
        issue(32'd10, 32'd10);
      end
      if (c == 36) bus_if.start = 1'b0;
    end
    checks++;
    if (bus_if.product !== 64'd100 || state_o !== 2'd0) begin
      failures++;
      $display("FAIL b2b_final: product=%h state=%0d required 100 state=0", bus_if.product, state_o);
    end
    exp_q.delete();
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.multiplicand = '0;
    test_reset();
    test_products();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Load and shift must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus_if.load && bus_if.shift) begin
        failures++;
        $display("FAIL load_shift_excl: load=1 shift=1 required not both");
      end
    end
  end
endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequencer and accumulator for the iterative shift-add multiplier. It drives load/shift of the multiplier shift register, consumes that register's LSB each iteration, holds and left-shifts the multiplicand, and accumulates the 2*WIDTH-bit product. It sits directly beside the multiplier shift register and takes a start/done handshake from the issuing logic upstream.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
multiplicand  input  WIDTH  multiplicand operand; captured on the accepting start edge
lsb  input  1  current LSB of the multiplier shift register
load  output  1  load strobe to the multiplier shift register
shift  output  1  shift-right strobe to the multiplier shift register
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse when the product is valid
product  output  2*WIDTH  result; holds until the next accepted start

Behaviour:
- One clock; reset is asynchronous and active-high.
- While reset is high: state=IDLE, mcand_reg=0, product=0, cnt=0, load=0, shift=0, busy=0, done=0.
- States: IDLE, LOAD, RUN, DONE, stored in a registered state.
- load, shift, busy and done are Moore outputs decoded from state.
- IDLE:
  - If start=1 at a rising edge: mcand_reg <= zero-extended multiplicand (2*WIDTH bits), product <= 0, cnt <= 0, state <= LOAD.
  - Otherwise hold all registers; product keeps the last result.
- LOAD (1 cycle):
  - load=1, shift=0, busy=1.
  - The multiplier register captures its operand at this edge. The multiplier operand must be valid during this cycle.
  - Next state is RUN.
- RUN (exactly WIDTH cycles):
  - shift=1, load=0, busy=1.
  - Each edge: if lsb=1 then product <= product + mcand_reg (2*WIDTH-bit add, no carry-out possible).
  - Each edge: mcand_reg <= mcand_reg << 1 (MSB dropped, zero-filled), cnt <= cnt + 1.
  - When cnt == WIDTH-1 at an edge: the final accumulate still occurs, and state <= DONE.
- DONE (1 cycle):
  - done=1, busy=0, load=0, shift=0.
  - Next state is IDLE.
- Latency: start sampled at edge 0 -> LOAD in cycle 1 -> RUN in cycles 2..WIDTH+1 -> done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- Boundary conditions:
  - start is ignored in LOAD, RUN and DONE; no queuing.
  - start high in the cycle DONE returns to IDLE is accepted normally.
  - start held high continuously gives back-to-back multiplies, one every WIDTH+3 cycles.
  - No early termination: a zero multiplier still takes the full WIDTH iterations.
  - Reset asserted mid-operation returns to IDLE with product cleared. No done pulse is produced for the aborted operation.
  - load and shift are never both high.

Test Plan:
- reset, start with multiplicand=5, multiplier register loaded with 3 -> load high only in cycle 1, shift high in cycles 2..33, done pulse in cycle 34, product=64'd15.
- multiplicand=32'hFFFFFFFF, multiplier=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 at done; no overflow.
- multiplicand=32'h12345678, multiplier=0 -> product=0, done still in cycle 34.
- start pulsed again in cycles 5 and 20 of a running multiply (7*9) -> ignored; single done; product=63.
- reset asserted in cycle 15 of a multiply -> state IDLE, product=0, busy=0, no done; next start (2*6) -> product=12.
- start held high for two operations (4*4, then 10*10) -> done pulses in cycles 34 and 69; product 16, then 100; product stable between them.
